uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART transmit serializer, downstream of uart_baud_rate. Consumes the one-cycle
//   baud_tick strobe (one strobe per bit period) and shifts out a parallel word.
//   Frame order: start bit, DATA_BITS data bits LSB first, optional parity, stop bit(s).
//   A valid/ready handshake on the parallel side accepts one word per frame.
// PARAMETERS
//   DATA_BITS   8   data bits per frame; legal range 5..9
//   PARITY_EN   0   1 = append a parity bit after the data bits
//   PARITY_ODD  0   with PARITY_EN=1: 0 = even parity, 1 = odd parity
//   STOP_BITS   1   stop bits per frame; legal values 1 or 2
// PORTS
//   clk        in   1          system clock; all logic on posedge
//   rst        in   1          synchronous, active-high reset
//   baud_tick  in   1          one-cycle bit-period strobe from uart_baud_rate
//   tx_data    in   DATA_BITS  word to send; sampled only at handshake
//   tx_valid   in   1          tx_data is valid
//   tx_ready   out  1          block can accept a word (high only in IDLE)
//   tx         out  1          serial line; idle/mark = 1
//   tx_busy    out  1          frame pending or in progress (= ~tx_ready)
//   tx_done    out  1          one-cycle pulse when the final stop bit period ends
// BEHAVIOUR
//   All outputs are registered. Reset values: tx=1, tx_ready=1, tx_busy=0,
//   tx_done=0, state=IDLE, shift register and counters cleared.
//   Handshake: transfer occurs on a posedge with tx_valid & tx_ready. tx_data is
//   latched into the shift register and tx_ready drops on the next cycle.
//   tx_valid is ignored while tx_ready=0, and that word is not queued.
//   State machine (line changes only on baud_tick, except at reset):
//     IDLE   tx=1; on handshake -> ARM
//     ARM    wait; on the next baud_tick (strictly after the handshake cycle) tx<=0 -> START
//            (a baud_tick coincident with the handshake cycle is not used)
//     START  on baud_tick: tx<=shift[0], bit count=0 -> DATA
//     DATA   on baud_tick: shift right, count++; after DATA_BITS bits -> PARITY if
//            PARITY_EN, else tx<=1 -> STOP
//     PARITY tx = ^data (even) or ~^data (odd), computed on the latched word;
//            on baud_tick tx<=1 -> STOP
//     STOP   each stop bit lasts one bit period; on the baud_tick ending the last stop
//            bit -> IDLE, with tx_ready<=1, tx_busy<=0 and tx_done<=1 for exactly 1 cycle
//   Each bit (start/data/parity/stop) is held exactly one baud_tick interval.
//   Back-to-back frames: the next word can be accepted the cycle after tx_done. Its
//   start bit begins on the following baud_tick, which gives at least one extra mark
//   period between frames (a legal line idle).
//   baud_tick held high continuously: one bit per clock, and the sequence above is unchanged.
//   Reset mid-frame: the frame is aborted, tx returns to 1 the cycle after rst, and no tx_done.
//   Out-of-range parameters are not supported (the bench checks legal values only).
// TESTING
//   1 8N1, ticks every 4 clk, send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1 (start..stop),
//     each held 4 clk; tx_done pulses once at the end of the stop bit; tx_ready then 1.
//   2 PARITY_EN=1 even, send 0x07 -> parity bit 1; PARITY_ODD=1, send 0x00 -> parity 1.
//   3 STOP_BITS=2, DATA_BITS=7, send 0x41 -> 0,1,0,0,0,0,0,1,1,1; tx_done after 2nd stop.
//   4 tx_valid held high with 0xA3 then 0x3C, changing during the frame -> exactly 0xA3
//     sent first and 0x3C second; no words dropped or duplicated; mark gap >= 1 bit.
//   5 Assert rst in the middle of data bit 3 -> next cycle tx=1, tx_ready=1, tx_done=0;
//     a new word sent afterwards produces a correct frame.
//   6 Handshake in the same cycle as baud_tick -> the start bit begins at the following tick.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer paced by an external one-cycle baud_tick strobe.
// Frame on tx: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. One word is accepted per frame over a valid/ready handshake.
module uart_tx #(
    parameter int DATA_BITS  = 8,   // 5..9
    parameter int PARITY_EN  = 0,   // 1 = append parity bit
    parameter int PARITY_ODD = 0,   // 0 = even, 1 = odd (only with PARITY_EN)
    parameter int STOP_BITS  = 1    // 1 or 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_cnt;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_accept;

    assign w_accept = tx_valid & r_ready;

    // Frame sequencer: every line change is gated by baud_tick, so each bit lasts one tick interval.
    always_ff @(posedge clk) begin
        // NOTE: tx_done is a one-cycle pulse; defaulting it low here, ahead of the case, means
        // only the stop-bit exit has to raise it and every other path clears it automatically.
        r_done <= 1'b0;
        if (rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift  <= tx_data;
                        // Parity is taken from the word as latched, not from the shifting copy.
                        r_parity <= (^tx_data) ^ PAR_ODD;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_ARM;
                    end
                end
                S_ARM: begin
                    // A tick in the handshake cycle was seen while still in IDLE, so it is skipped.
                    if (baud_tick) begin
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (r_cnt == LAST_DATA) begin
                            r_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tick) begin
                        r_tx    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        if (r_cnt == LAST_STOP) begin
                            r_cnt   <= '0;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four uart_tx configurations (8N1, 9E1, 5O2, 7N2) on a shared clock,
// reset and baud_tick, compared every cycle against a frame-as-bit-vector model.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic [3:0] tx_valid;
    logic [8:0] tx_data [4];
    logic [3:0] tx_ready;
    logic [3:0] tx_line;
    logic [3:0] tx_busy;
    logic [3:0] tx_done;

    int n_pass   = 0;
    int n_checks = 0;
    bit chk_en   = 1'b0;
    int tick_mode = 1;  // 0 = every cycle, 1 = every 4th cycle, 2 = random
    int tick_cnt  = 0;

    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data[0][7:0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx(tx_line[0]),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
    uart_tx #(.DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data[1]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx(tx_line[1]),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
    uart_tx #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data[2][4:0]),
        .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .tx(tx_line[2]),
        .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
    uart_tx #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data[3][6:0]),
        .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]), .tx(tx_line[3]),
        .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

    // Configuration of each instance, as seen by the model.
    function automatic int cfg_db(input int i);
        case (i)
            0:       return 8;
            1:       return 9;
            2:       return 5;
            default: return 7;
        endcase
    endfunction
    function automatic int cfg_pen(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_podd(input int i);
        return (i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(input int i);
        return (i == 2 || i == 3) ? 2 : 1;
    endfunction

    // Whole frame as line values in transmit order (bit 0 = start); unused upper bits are mark.
    function automatic logic [15:0] make_frame(input int db, input int pen, input int podd,
                                               input logic [8:0] d);
        logic [15:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int k = 0; k < db; k++) begin
            f[k+1] = d[k];
            ones  += int'(d[k]);
        end
        if (pen != 0) f[db+1] = ((ones % 2) == 1) ^ (podd != 0);
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state: the pending frame, how far along it is, and the expected outputs.
    logic [15:0] m_frame [4] = '{default: '1};
    int          m_len   [4] = '{default: 0};
    int          m_pos   [4] = '{default: 0};
    logic        m_tx    [4] = '{default: 1'b1};
    logic        m_ready [4] = '{default: 1'b1};
    logic        m_done  [4] = '{default: 1'b0};
    int          done_cnt[4] = '{default: 0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // baud_tick source; changes on the falling edge so it is stable at each rising edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_mode == 0) begin
                baud_tick = 1'b1;
            end else if (tick_mode == 1) begin
                tick_cnt  = (tick_cnt + 1) % 4;
                baud_tick = (tick_cnt == 0);
            end else begin
                baud_tick = ($urandom_range(0, 2) == 0);
            end
        end
    end

    // Reference model: a frame is accepted when idle, then each tick puts its next bit on the
    // line; the tick after the last stop bit has been shown ends the frame with a done pulse.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            m_done[i] <= 1'b0;
            if (rst) begin
                m_tx[i]    <= 1'b1;
                m_ready[i] <= 1'b1;
                m_pos[i]   <= 0;
                m_len[i]   <= 0;
            end else if (m_ready[i]) begin
                if (tx_valid[i] === 1'b1) begin
                    m_frame[i] <= make_frame(cfg_db(i), cfg_pen(i), cfg_podd(i), tx_data[i]);
                    m_len[i]   <= 1 + cfg_db(i) + cfg_pen(i) + cfg_sb(i);
                    m_pos[i]   <= 0;
                    m_ready[i] <= 1'b0;
                end
            end else if (baud_tick === 1'b1) begin
                if (m_pos[i] < m_len[i]) begin
                    m_tx[i]  <= m_frame[i][m_pos[i]];
                    m_pos[i] <= m_pos[i] + 1;
                end else begin
                    m_tx[i]    <= 1'b1;
                    m_ready[i] <= 1'b1;
                    m_done[i]  <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every output of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("dut%0d_tx", i),    32'(tx_line[i]),  32'(m_tx[i]));
                check($sformatf("dut%0d_ready", i), 32'(tx_ready[i]), 32'(m_ready[i]));
                check($sformatf("dut%0d_busy", i),  32'(tx_busy[i]),  32'(!m_ready[i]));
                check($sformatf("dut%0d_done", i),  32'(tx_done[i]),  32'(m_done[i]));
            end
        end
    end

    // Counts done pulses per instance for the directed tests.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (tx_done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end

    task automatic idle(input int n);
        tx_valid = '0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Offer word d to instance i and hold it until one handshake edge has passed.
    task automatic send(input int i, input logic [8:0] d);
        int guard;
        guard       = 0;
        tx_data[i]  = d;
        tx_valid[i] = 1'b1;
        while (tx_ready[i] !== 1'b1 && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check($sformatf("dut%0d_send_ready_seen", i), 32'(guard < 200), 32'd1);
        @(negedge clk);
        #1;
        tx_valid[i] = 1'b0;
    endtask

    // Wait for the start bit, then sample the first cycle of each of nbits bit periods.
    // When the start bit appears, valid/data are set to the given next values.
    task automatic capture(input int i, input int nbits, input int bit_cyc,
                           input logic nxt_valid, input logic [8:0] nxt_data,
                           output logic [15:0] bits, output int wait_cyc);
        wait_cyc = 0;
        bits     = '1;
        while (tx_line[i] !== 1'b0 && wait_cyc < 200) begin
            @(negedge clk);
            #1;
            wait_cyc++;
        end
        check($sformatf("dut%0d_start_seen", i), 32'(wait_cyc < 200), 32'd1);
        tx_valid[i] = nxt_valid;
        tx_data[i]  = nxt_data;
        for (int k = 0; k < nbits; k++) begin
            bits[k] = tx_line[i];
            repeat (bit_cyc) @(negedge clk);
            #1;
        end
    endtask

    initial begin
        logic [15:0] bits;
        int          w;
        int          d0;
        int          g;

        rst      = 1'b1;
        tx_valid = '0;
        for (int i = 0; i < 4; i++) tx_data[i] = '0;

        // Hand-computed frames pin the model's frame builder.
        check("model_8n1_55",  32'(make_frame(8, 0, 0, 9'h055)), 32'h0000FEAA);
        check("model_5o2_00",  32'(make_frame(5, 1, 1, 9'h000)), 32'h0000FFC0);
        check("model_9e1_07",  32'(make_frame(9, 1, 0, 9'h007)), 32'h0000FC0E);

        repeat (2) @(negedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dut%0d_reset_tx", i),    32'(tx_line[i]),  32'd1);
            check($sformatf("dut%0d_reset_ready", i), 32'(tx_ready[i]), 32'd1);
            check($sformatf("dut%0d_reset_busy", i),  32'(tx_busy[i]),  32'd0);
            check($sformatf("dut%0d_reset_done", i),  32'(tx_done[i]),  32'd0);
        end
        idle(4);

        // 8N1, tick every 4 clocks, 0x55.
        d0 = done_cnt[0];
        send(0, 9'h055);
        capture(0, 10, 4, 1'b0, 9'h000, bits, w);
        check("t1_frame_55", 32'(bits[9:0]), 32'h2AA);
        check("t1_done_once", 32'(done_cnt[0] - d0), 32'd1);
        check("t1_ready_after", 32'(tx_ready[0]), 32'd1);
        idle(6);

        // Even parity on 9 data bits, odd parity on 5 data bits with 2 stops.
        send(1, 9'h007);
        capture(1, 12, 4, 1'b0, 9'h000, bits, w);
        check("t2_even_frame_07", 32'(bits[11:0]), 32'hC0E);
        check("t2_even_parity_bit", 32'(bits[10]), 32'd1);
        idle(4);
        send(2, 9'h000);
        capture(2, 9, 4, 1'b0, 9'h000, bits, w);
        check("t2_odd_frame_00", 32'(bits[8:0]), 32'h1C0);
        idle(6);

        // 7 data bits, 2 stop bits, 0x41; done only after the second stop bit.
        d0 = done_cnt[3];
        send(3, 9'h041);
        capture(3, 10, 4, 1'b0, 9'h000, bits, w);
        check("t3_frame_41", 32'(bits[9:0]), 32'h382);
        check("t3_done_once", 32'(done_cnt[3] - d0), 32'd1);
        idle(6);

        // tx_valid held high across two frames while the data changes mid-frame.
        d0          = done_cnt[0];
        tx_data[0]  = 9'h0A3;
        tx_valid[0] = 1'b1;
        capture(0, 10, 4, 1'b1, 9'h03C, bits, w);
        check("t4_first_A3", 32'(bits[9:0]), 32'h346);
        capture(0, 10, 4, 1'b0, 9'h000, bits, w);
        check("t4_second_3C", 32'(bits[9:0]), 32'h278);
        check("t4_mark_gap", 32'(w >= 4), 32'd1);
        idle(16);
        check("t4_two_frames_only", 32'(done_cnt[0] - d0), 32'd2);
        check("t4_line_idle", 32'(tx_line[0]), 32'd1);

        // Reset in the middle of data bit 3, then a clean frame.
        send(0, 9'h0B6);
        d0 = done_cnt[0];
        capture(0, 0, 4, 1'b0, 9'h000, bits, w);
        repeat (17) @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        check("t5_tx_after_rst", 32'(tx_line[0]), 32'd1);
        check("t5_ready_after_rst", 32'(tx_ready[0]), 32'd1);
        check("t5_done_after_rst", 32'(tx_done[0]), 32'd0);
        idle(20);
        check("t5_no_done_for_abort", 32'(done_cnt[0] - d0), 32'd0);
        send(0, 9'h05A);
        capture(0, 10, 4, 1'b0, 9'h000, bits, w);
        check("t5_frame_after_rst", 32'(bits[9:0]), 32'h2B4);
        idle(6);

        // Handshake in the same cycle as a tick: start bit begins one full tick later.
        g = 0;
        while (baud_tick !== 1'b1 && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        send(0, 9'h00F);
        capture(0, 10, 4, 1'b0, 9'h000, bits, w);
        check("t6_start_delay", 32'(w), 32'd4);
        check("t6_frame_0F", 32'(bits[9:0]), 32'h21E);
        idle(6);

        // Tick high every cycle: one bit per clock.
        tick_mode = 0;
        idle(4);
        send(3, 9'h02A);
        capture(3, 10, 1, 1'b0, 9'h000, bits, w);
        check("t7_continuous_2A", 32'(bits[9:0]), 32'h354);
        idle(4);

        // Randomized traffic: random ticks, then continuous ticks, rare random resets.
        tick_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (c == 2000) tick_mode = 0;
            for (int i = 0; i < 4; i++) begin
                tx_valid[i] = ($urandom_range(0, 3) == 0);
                tx_data[i]  = 9'($urandom);
            end
            rst = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0;
        idle(40);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
